// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute handshake bundle for the issue/hazard controller.
// master = decode/execute side, slave = the controller.
interface pipe_hazard_ctrl_if;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_useRs1_i;
    logic        id_useRs2_i;
    logic [4:0]  id_rd_i;
    logic        id_regWrite_i;
    logic        ex_branchTaken_i;
    logic        issue_o;
    logic        stall_o;
    logic        flush_o;
    logic [15:0] stallCnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_useRs1_i, id_useRs2_i,
        output id_rd_i, id_regWrite_i, ex_branchTaken_i,
        input  issue_o, stall_o, flush_o, stallCnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_useRs1_i, id_useRs2_i,
        input  id_rd_i, id_regWrite_i, ex_branchTaken_i,
        output issue_o, stall_o, flush_o, stallCnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Issue/hazard controller between decode and execute: RAW scoreboard stall,
// fixed-length flush on taken branch, saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  io_bus
);
    localparam int SbLen = int'(DEPTH);
    localparam int unsigned FcntW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FcntW-1:0] FcntReload = FcntW'(FLUSH_CYCLES - 1);

    typedef enum logic {StRun, StFlush} state_e;

    state_e           r_state;
    logic [FcntW-1:0] r_fcnt;
    logic [SbLen-1:0] r_sb_v;
    logic [4:0]       r_sb_rd [SbLen];
    logic [15:0]      r_stall_cnt;

    logic w_hit1;
    logic w_hit2;
    logic w_hazard;
    logic w_flush;
    logic w_stall;
    logic w_issue;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < SbLen; i++) begin
            if (r_sb_v[i] && (r_sb_rd[i] == io_bus.id_rs1_i)) w_hit1 = 1'b1;
            if (r_sb_v[i] && (r_sb_rd[i] == io_bus.id_rs2_i)) w_hit2 = 1'b1;
        end
        w_hit1   = w_hit1 & io_bus.id_useRs1_i & (io_bus.id_rs1_i != 5'd0);
        w_hit2   = w_hit2 & io_bus.id_useRs2_i & (io_bus.id_rs2_i != 5'd0);
        w_hazard = io_bus.id_valid_i & (w_hit1 | w_hit2);
    end

    // Gated by rst_n so all three go low the moment reset asserts.
    assign w_flush = rst_n & ((r_state == StFlush) | io_bus.ex_branchTaken_i);
    assign w_stall = rst_n & ~w_flush & w_hazard;
    assign w_issue = rst_n & ~w_flush & io_bus.id_valid_i & ~w_hazard;

    assign io_bus.issue_o    = w_issue;
    assign io_bus.stall_o    = w_stall;
    assign io_bus.flush_o    = w_flush;
    assign io_bus.stallCnt_o = r_stall_cnt;

    // Flush does not clear the scoreboard; wrong-path entries just age out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_v <= '0;
            for (int i = 0; i < SbLen; i++) r_sb_rd[i] <= 5'd0;
        end else begin
            for (int i = 1; i < SbLen; i++) begin
                r_sb_v[i]  <= r_sb_v[i-1];
                r_sb_rd[i] <= r_sb_rd[i-1];
            end
            r_sb_v[0]  <= w_issue & io_bus.id_regWrite_i & (io_bus.id_rd_i != 5'd0);
            r_sb_rd[0] <= io_bus.id_rd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRun;
            r_fcnt  <= '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (io_bus.ex_branchTaken_i && (FLUSH_CYCLES > 1)) begin
                        r_state <= StFlush;
                        r_fcnt  <= FcntReload;
                    end
                end
                StFlush: begin
                    if (io_bus.ex_branchTaken_i) begin
                        r_fcnt <= FcntReload;
                    end else begin
                        r_fcnt <= r_fcnt - 1'b1;
                        if (r_fcnt == FcntW'(1)) r_state <= StRun;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: reference model pushes expected outputs,
// a monitor pops and compares; a second instance exercises counter saturation.
module tb_pipe_hazard_ctrl;
    localparam int unsigned DEPTH        = 3;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned SAT_DEPTH    = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic sat_rst_n;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();
    pipe_hazard_ctrl_if sat_bus ();

    pipe_hazard_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    pipe_hazard_ctrl #(.DEPTH(SAT_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) sat_dut (
        .clk    (clk),
        .rst_n  (sat_rst_n),
        .io_bus (sat_bus)
    );

    typedef struct {
        logic        issue;
        logic        stall;
        logic        flush;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int rd;
        int age;
    } inflight_t;

    exp_t      exp_q[$];
    inflight_t pend[$];
    int        m_rem = 0;
    int        m_cnt = 0;
    bit        stim_done = 1'b0;
    int        checks = 0;
    int        failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit busy(input int r);
        foreach (pend[i]) if (pend[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_rem = 0;
        m_cnt = 0;
    endtask

    // One decode cycle: drive inputs at negedge and queue the model's expectation.
    task automatic step(input bit rst, input bit v, input int rs1, input int rs2, input bit u1,
                        input bit u2, input int rd, input bit rw, input bit br);
        exp_t e;
        bit   haz;
        bit   fl;
        @(negedge clk);
        rst_n                = ~rst;
        bus.id_valid_i       = v;
        bus.id_rs1_i         = 5'(rs1);
        bus.id_rs2_i         = 5'(rs2);
        bus.id_useRs1_i      = u1;
        bus.id_useRs2_i      = u2;
        bus.id_rd_i          = 5'(rd);
        bus.id_regWrite_i    = rw;
        bus.ex_branchTaken_i = br;
        if (rst) begin
            model_reset();
            e = '{issue: 1'b0, stall: 1'b0, flush: 1'b0, cnt: 16'd0};
            exp_q.push_back(e);
            return;
        end
        haz = v && ((u1 && rs1 != 0 && busy(rs1)) || (u2 && rs2 != 0 && busy(rs2)));
        fl  = br || (m_rem > 0);
        e.flush = fl;
        e.stall = !fl && haz;
        e.issue = !fl && v && !haz;
        e.cnt   = 16'(m_cnt);
        exp_q.push_back(e);
        m_rem = br ? int'(FLUSH_CYCLES) - 1 : ((m_rem > 0) ? m_rem - 1 : 0);
        if (e.stall && m_cnt < 65535) m_cnt++;
        foreach (pend[i]) pend[i].age++;
        for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].age > int'(DEPTH)) pend.delete(i);
        if (e.issue && rw && rd != 0) pend.push_back('{rd: rd, age: 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        sat_rst_n = 1'b0;
        fork
            begin : stim
                for (int i = 0; i < 3; i++)
                    step(1, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
                         1'($urandom), 1'($urandom), $urandom_range(0, 31), 1'($urandom),
                         1'($urandom));
                step(0, 1, 0, 0, 0, 0, 3, 1, 0);
                idle(4);
                // RAW: producer rd=5, consumer stalls DEPTH cycles then issues
                step(0, 1, 0, 0, 0, 0, 5, 1, 0);
                for (int i = 0; i < 4; i++) step(0, 1, 5, 0, 1, 0, 9, 0, 0);
                // x0 producer/consumer, then unused rs2
                step(0, 1, 0, 0, 0, 0, 0, 1, 0);
                step(0, 1, 0, 0, 1, 0, 8, 0, 0);
                idle(4);
                step(0, 1, 0, 0, 0, 0, 7, 1, 0);
                step(0, 1, 0, 7, 0, 0, 10, 0, 0);
                idle(4);
                // Taken branch while a hazard is pending
                step(0, 1, 0, 0, 0, 0, 6, 1, 0);
                step(0, 1, 6, 0, 1, 0, 11, 0, 1);
                for (int i = 0; i < 4; i++) step(0, 1, 6, 0, 1, 0, 11, 0, 0);
                idle(4);
                // Back-to-back branches
                step(0, 1, 0, 0, 0, 0, 12, 0, 1);
                step(0, 1, 0, 0, 0, 0, 12, 0, 1);
                step(0, 1, 0, 0, 0, 0, 12, 0, 0);
                step(0, 1, 0, 0, 0, 0, 12, 0, 0);
                // Asynchronous reset during a stall
                step(0, 1, 0, 0, 0, 0, 4, 1, 0);
                step(0, 1, 4, 0, 1, 0, 13, 0, 0);
                #3 rst_n = 1'b0;
                #1;
                check("async_rst_issue", 16'(bus.issue_o), 16'd0);
                check("async_rst_stall", 16'(bus.stall_o), 16'd0);
                check("async_rst_flush", 16'(bus.flush_o), 16'd0);
                check("async_rst_cnt", bus.stallCnt_o, 16'd0);
                model_reset();
                step(1, 1, 4, 0, 1, 0, 13, 0, 1);
                step(0, 1, 4, 0, 1, 0, 13, 0, 0);
                for (int i = 0; i < 2000; i++)
                    step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                         $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                         $urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 9) == 0));
                stim_done = 1'b1;
            end
            begin : mon
                exp_t e;
                int   guard = 0;
                while ((!stim_done || exp_q.size() > 0) && guard < 20000) begin
                    @(negedge clk);
                    #2;
                    guard++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("issue", 16'(bus.issue_o), 16'(e.issue));
                        check("stall", 16'(bus.stall_o), 16'(e.stall));
                        check("flush", 16'(bus.flush_o), 16'(e.flush));
                        check("stallCnt", bus.stallCnt_o, e.cnt);
                    end
                end
                if (guard >= 20000) check("monitor_timeout", 16'(exp_q.size()), 16'd0);
            end
            begin : sat
                int c;
                sat_bus.id_valid_i       = 1'b1;
                sat_bus.id_rs1_i         = 5'd5;
                sat_bus.id_rs2_i         = 5'd0;
                sat_bus.id_useRs1_i      = 1'b1;
                sat_bus.id_useRs2_i      = 1'b0;
                sat_bus.id_rd_i          = 5'd5;
                sat_bus.id_regWrite_i    = 1'b1;
                sat_bus.ex_branchTaken_i = 1'b0;
                repeat (2) @(negedge clk);
                sat_rst_n = 1'b1;
                // Self-dependent chain: one issue then SAT_DEPTH stalls, repeating
                c = 1000;
                repeat (c) @(negedge clk);
                #1;
                check("sat_partial_cnt", sat_bus.stallCnt_o,
                      16'(c - (c + int'(SAT_DEPTH)) / (int'(SAT_DEPTH) + 1)));
                repeat (71000) @(negedge clk);
                #1;
                check("sat_cnt", sat_bus.stallCnt_o, 16'hFFFF);
                repeat (50) @(negedge clk);
                #1;
                check("sat_hold", sat_bus.stallCnt_o, 16'hFFFF);
                #2 sat_rst_n = 1'b0;
                #1;
                check("sat_async_rst_cnt", sat_bus.stallCnt_o, 16'd0);
                check("sat_async_rst_stall", 16'(sat_bus.stall_o), 16'd0);
                check("sat_async_rst_issue", 16'(sat_bus.issue_o), 16'd0);
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Issue/hazard controller sitting between the decode stage and the execute stage of the pipelined sr_cpu. It keeps a scoreboard of destination registers still in flight. It stalls decode on read-after-write hazards and sequences a fixed-length pipeline flush when execute resolves a taken branch. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
DEPTH, 3, cycles from issue until a result is visible in the register file; this is the scoreboard length (>=1).
FLUSH_CYCLES, 2, total cycles flush_o stays high per taken branch, including the branch cycle (>=1).

Ports:
clk  in  1  system clock, all state updated on posedge
rst_n  in  1  reset; asynchronous, active-low
id_valid_i  in  1  decode holds a valid instruction
id_rs1_i  in  5  source register 1 index
id_rs2_i  in  5  source register 2 index
id_useRs1_i  in  1  instruction reads rs1
id_useRs2_i  in  1  instruction reads rs2
id_rd_i  in  5  destination register index
id_regWrite_i  in  1  instruction writes rd
ex_branchTaken_i  in  1  execute resolved a taken branch this cycle
issue_o  out  1  decode instruction advances into execute this cycle
stall_o  out  1  hold PC/decode registers, inject bubble into execute
flush_o  out  1  kill fetch/decode contents, inject bubble
stallCnt_o  out  16  saturating count of cycles with stall_o=1

Behaviour:
- Reset (rst_n=0, asynchronous): all scoreboard entries invalid; FSM = RUN; flush counter = 0; stallCnt_o = 0. With rst_n low, issue_o, stall_o and flush_o are all 0, regardless of inputs.
- Scoreboard: sb[0..DEPTH-1], each entry {v, rd[4:0]}.
  - Every posedge: sb[i] <= sb[i-1] for i>=1.
  - sb[0] <= {issue_o & id_regWrite_i & (id_rd_i!=0), id_rd_i}; otherwise v=0.
  - Entries are not cleared by a flush. Wrong-path entries age out normally. This is conservative and causes extra stalls only.
- hazard (combinational):
  - hit1 = id_useRs1_i & (id_rs1_i!=0) & any(sb[i].v & sb[i].rd==id_rs1_i).
  - hit2 is the same check for rs2.
  - hazard = id_valid_i & (hit1 | hit2). Register x0 never causes a hazard.
- FSM states: RUN, FLUSH. The flush counter fcnt is $clog2(FLUSH_CYCLES+1) bits wide.
  - RUN, ex_branchTaken_i=1: flush_o=1, issue_o=0, stall_o=0. If FLUSH_CYCLES>1, next state is FLUSH with fcnt<=FLUSH_CYCLES-1; otherwise stay in RUN.
  - RUN, no branch: flush_o=0, stall_o=hazard, issue_o=id_valid_i & ~hazard.
  - FLUSH: flush_o=1, issue_o=0, stall_o=0.
    - ex_branchTaken_i=1 reloads fcnt<=FLUSH_CYCLES-1 and the FSM stays in FLUSH.
    - Otherwise fcnt decrements; at fcnt==1 the next state is RUN.
- Priority when events coincide: taken branch > hazard stall > issue. issue_o, stall_o and flush_o are mutually exclusive in every cycle.
- Outputs issue_o, stall_o, flush_o are combinational from state and inputs. They are valid in the same cycle, so decode uses them at the next posedge.
- Latency: if a consumer is presented in the cycle after its producer issued, it stalls DEPTH cycles and issues in cycle DEPTH+1 after the producer.
- stallCnt_o: increments at each posedge where stall_o=1. It holds at 16'hFFFF and never wraps. Only reset clears it.
- Reset asserted mid-flush or mid-stall takes effect immediately: the FSM returns to RUN and all scoreboard state is lost.

Test Plan:
- Reset values: hold rst_n=0 with arbitrary inputs. Required: issue_o=stall_o=flush_o=0 and stallCnt_o=0. Release rst_n, present an instruction with id_valid_i=1 and no sources. Required: issue_o=1 in the first cycle.
- RAW stall (DEPTH=3): cycle 0 issue rd=5, regWrite=1; cycle 1 present rs1=5, useRs1=1. Required: stall_o=1 in cycles 1..3, issue_o=1 in cycle 4, stallCnt_o=3.
- x0 and unused sources: producer writes rd=0 followed by a consumer of rs1=0; separately, a producer of rd=7 followed by a consumer with rs2=7 and useRs2=0. Required: no stall in either case, issue_o=1 in cycle 1.
- Taken branch (FLUSH_CYCLES=2): ex_branchTaken_i=1 in cycle 10 while a hazard is pending. Required: flush_o=1 in cycles 10 and 11, stall_o=0 and issue_o=0 in both cycles, RUN resumes in cycle 12.
- Back-to-back branches: ex_branchTaken_i=1 in cycles 10 and 11. Required: flush_o=1 in cycles 10–12, issue_o=1 in cycle 13 when no hazard is pending.
- Saturation: force a permanent hazard for 70000 cycles. Required: stallCnt_o=16'hFFFF and held there; drop rst_n mid-run. Required: stallCnt_o=0 immediately, without waiting for a clock edge.
